spi_minion_ifc: RTL and testbench
=================================

Name: spi_minion_ifc

Overview:
- SPI minion (slave) endpoint that sits directly downstream of the SPI master, on the far side of the cs0/sclk/mosi/miso wires.
- Converts serial frames into val/rdy stream messages, and stream messages into serial replies.
- SPI mode 0: CPOL=0, CPHA=0, MSB first.
- cs, sclk and mosi are oversampled in the clk domain; clk must be at least 8x the sclk frequency.

Parameters:
- NBITS, 8, payload bits per frame and width of both message ports.
- SYNC_STAGES, 2, flops in each input synchronizer; legal range 2–3.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  chip select from master, active-low
- sclk  in  1  serial clock from master
- mosi  in  1  serial data from master
- miso  out  1  serial data to master
- recv_msg  out  NBITS  last complete frame received from master
- recv_val  out  1  recv_msg valid
- recv_rdy  in  1  consumer accepts recv_msg
- send_msg  in  NBITS  reply word for the next frame
- send_val  in  1  send_msg valid
- send_rdy  out  1  send_msg accepted this cycle
- overflow  out  1  sticky: a complete frame was dropped
- busy  out  1  a frame is in progress

Behaviour:
- Reset (async, active-high) values:
  - miso=0, recv_msg=0, recv_val=0, send_rdy=0, overflow=0, busy=0.
  - All shift registers, the bit counter and the synchronizers clear.
  - Synchronizer cs stages reset to 1 (deasserted).
- Synchronization: cs, sclk and mosi each pass through SYNC_STAGES flops. Edges are detected from the last synced stage vs one extra delayed flop:
  - cs_fall, cs_rise
  - sclk_rise, sclk_fall
- FSM states: IDLE, ACTIVE.
- IDLE → ACTIVE on cs_fall:
  - Bit counter cleared.
  - If send_val=1: tx shreg loads send_msg and send_rdy=1 for exactly this cycle (transfer occurs).
  - Otherwise tx shreg loads all zeros and send_rdy=0.
  - busy=1 from the next cycle.
- In ACTIVE:
  - On sclk_rise: rx shreg shifts left, LSB <= synced mosi; counter increments, saturating at NBITS+1.
  - On sclk_fall: tx shreg shifts left, zero-filled.
  - miso is always driven from tx shreg MSB, so the first bit is valid before the first sclk rise.
- ACTIVE → IDLE on cs_rise; busy=0 next cycle.
  - If counter == NBITS and the output buffer is empty or being drained this cycle (recv_val=0, or recv_rdy=1): recv_msg <= rx shreg, recv_val=1 next cycle.
  - If counter == NBITS and the buffer is full with recv_rdy=0: frame dropped, overflow set to 1.
  - If counter != NBITS (short or long frame): frame discarded silently; recv_val and overflow unchanged.
- recv_val stays high until a cycle with recv_val & recv_rdy, after which it falls. recv_msg is stable while recv_val=1.
- overflow is cleared only by reset.
- Simultaneous events:
  - sclk edge in the same cycle as cs_rise: the sclk edge is ignored.
  - cs_fall while in ACTIVE is impossible; cs_rise while in IDLE is ignored.
- A cs glitch shorter than the synchronizer delay may be missed; this is legal.
- Reset mid-frame: immediate return to IDLE with outputs at reset values. The partial frame is lost; the next cs_fall starts cleanly.
- Latency:
  - cs pin rise to recv_val: SYNC_STAGES+2 clk cycles.
  - cs pin fall to send_rdy pulse: SYNC_STAGES+1 clk cycles.
- Counter width: $clog2(NBITS+2).

Optional Feature:
- Macro: SPI_MINION_FLOWCTRL_EN.
- Defined:
  - Frame length becomes NBITS+2.
  - The first two MISO bits are {send_valid_latched, recv_space}:
    - send_valid_latched = send_val at cs_fall.
    - recv_space = !recv_val at cs_fall.
    - Payload bits follow.
  - The first two MOSI bits are {master_val, master_rdy}.
  - The received payload is pushed only if counter == NBITS+2 and master_val=1. If master_val=0, the frame is discarded without setting overflow.
  - send_rdy pulses at cs_fall only if send_val=1 and master_rdy of the previous frame was 1. The register holding that bit resets to 1.
- Undefined: plain NBITS-bit frames exactly as in Behaviour; no header bits.

Test Plan (NBITS=8, clk = 10x sclk):
- Basic receive: cs low, mosi 0xA5 MSB first over 8 sclk, cs high, recv_rdy=1 → recv_val one cycle, recv_msg=0xA5, overflow=0.
- Basic send: send_val=1, send_msg=0x3C before cs_fall → send_rdy one-cycle pulse at cs_fall; miso bits 0,0,1,1,1,1,0,0 sampled on sclk rises.
- No data: send_val=0 during frame → miso all 0; send_rdy never 1.
- Backpressure and overflow:
  - recv_rdy=0, frames 0x11 then 0x22 → recv_msg stays 0x11 and overflow=1.
  - Then recv_rdy=1 → one transfer of 0x11, recv_val=0.
- Bad length: frames of 7 and 9 sclk pulses → no recv_val, overflow=0; a following 8-bit frame 0x5A is received correctly.
- Mid-frame reset: reset asserted after 4 bits → all outputs 0 immediately; the next full frame 0xC3 is received as 0xC3. With SPI_MINION_FLOWCTRL_EN defined: header bits {0,1} + 0xFF → frame dropped, overflow=0.

Source files
------------

// File: rtl/spi_minion_ifc.sv
// SPI mode-0 minion: oversamples cs/sclk/mosi and bridges frames to val/rdy streams.
// Optional SPI_MINION_FLOWCTRL_EN adds a two-bit flow-control header to every frame.
module spi_minion_ifc #(
  parameter int NBITS       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic [NBITS-1:0] recv_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  input  logic [NBITS-1:0] send_msg,
  input  logic             send_val,
  output logic             send_rdy,
  output logic             overflow,
  output logic             busy
);

`ifdef SPI_MINION_FLOWCTRL_EN
  localparam int FRAME = NBITS + 2;
`else
  localparam int FRAME = NBITS;
`endif
  localparam int CW = $clog2(FRAME + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   cs_d, sclk_d;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_t           state, state_next;
  logic             start, stop, shift_rx, shift_tx, hdr_ok;
  logic [FRAME-1:0] rx_shreg, tx_shreg;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

`ifdef SPI_MINION_FLOWCTRL_EN
  logic master_rdy_q;
  assign hdr_ok = rx_shreg[FRAME-1];
`else
  assign hdr_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    send_rdy   = 1'b0;
    unique case (state)
      IDLE: if (cs_fall) begin
        start      = 1'b1;
        state_next = ACTIVE;
      end
      ACTIVE: if (cs_rise) begin
        stop       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef SPI_MINION_FLOWCTRL_EN
    send_rdy = start & send_val & master_rdy_q;
`else
    send_rdy = start & send_val;
`endif
  end

  // cs_rise wins over a coincident sclk edge so a late edge cannot corrupt the frame
  assign shift_rx = (state == ACTIVE) & sclk_rise & ~cs_rise;
  assign shift_tx = (state == ACTIVE) & sclk_fall & ~cs_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_shreg <= '0;
      tx_shreg <= '0;
      cnt      <= '0;
      recv_msg <= '0;
      recv_val <= 1'b0;
      overflow <= 1'b0;
`ifdef SPI_MINION_FLOWCTRL_EN
      master_rdy_q <= 1'b1;
`endif
    end else begin
      if (start) begin
        cnt <= '0;
`ifdef SPI_MINION_FLOWCTRL_EN
        tx_shreg <= {send_val, ~recv_val, (send_rdy ? send_msg : {NBITS{1'b0}})};
`else
        tx_shreg <= send_rdy ? send_msg : '0;
`endif
      end else if (shift_tx) begin
        tx_shreg <= {tx_shreg[FRAME-2:0], 1'b0};
      end

      if (shift_rx) begin
        rx_shreg <= {rx_shreg[FRAME-2:0], mosi_s};
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end

      if (recv_val && recv_rdy) recv_val <= 1'b0;

      if (stop && cnt == CNT_FULL) begin
`ifdef SPI_MINION_FLOWCTRL_EN
        master_rdy_q <= rx_shreg[FRAME-2];
`endif
        if (hdr_ok) begin
          if (!recv_val || recv_rdy) begin
            recv_msg <= rx_shreg[NBITS-1:0];
            recv_val <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  assign miso = tx_shreg[FRAME-1];
  assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_spi_minion_ifc.sv
// Directed bench for spi_minion_ifc (default build, NBITS=8, clk = 10x sclk).
module tb_spi_minion_ifc;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] recv_msg;
  logic       recv_val;
  logic       recv_rdy = 1'b1;
  logic [7:0] send_msg = '0;
  logic       send_val = 1'b0;
  logic       send_rdy;
  logic       overflow;
  logic       busy;

  int total = 0;
  int bad = 0;
  int rdy_cnt = 0;
  int acc_cnt = 0;
  logic [7:0] last_acc = '0;

  spi_minion_ifc #(.NBITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (send_rdy) rdy_cnt++;
    if (recv_val && recv_rdy) begin
      acc_cnt++;
      last_acc = recv_msg;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic b, output logic m);
    mosi = b;
    wait_clk(5);
    m = miso;
    sclk = 1'b1;
    wait_clk(5);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [15:0] data, input int unsigned n, output logic [15:0] rxd);
    logic m;
    rxd = '0;
    cs = 1'b0;
    wait_clk(10);
    for (int unsigned i = 0; i < n; i++) begin
      sclk_bit(data[n-1-i], m);
      rxd = {rxd[14:0], m};
    end
    wait_clk(5);
    cs = 1'b1;
    mosi = 1'b0;
    wait_clk(12);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(3);
  endtask

  initial begin
    logic [15:0] rxd;
    logic m;
    int r0, a0;

    reset = 1'b1;
    wait_clk(3);
    check("rst_miso", miso, 0);
    check("rst_recv_msg", recv_msg, 0);
    check("rst_recv_val", recv_val, 0);
    check("rst_send_rdy", send_rdy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    wait_clk(3);

    // basic receive 0xA5 while replying 0x3C
    send_val = 1'b1;
    send_msg = 8'h3C;
    r0 = rdy_cnt; a0 = acc_cnt;
    frame(16'h00A5, 8, rxd);
    send_val = 1'b0;
    check("send_rdy_pulses", rdy_cnt - r0, 1);
    check("miso_bits", rxd[7:0], 8'h3C);
    check("rx_accepts", acc_cnt - a0, 1);
    check("rx_data", last_acc, 8'hA5);
    check("rx_val_after", recv_val, 0);
    check("rx_overflow", overflow, 0);
    check("busy_after", busy, 0);

    // no reply data
    r0 = rdy_cnt;
    frame(16'h00FF, 8, rxd);
    check("nodata_miso", rxd[7:0], 8'h00);
    check("nodata_rdy", rdy_cnt - r0, 0);
    check("nodata_rx", last_acc, 8'hFF);

    // backpressure and overflow
    recv_rdy = 1'b0;
    wait_clk(2);
    a0 = acc_cnt;
    frame(16'h0011, 8, rxd);
    check("bp_val1", recv_val, 1);
    check("bp_msg1", recv_msg, 8'h11);
    check("bp_ovf1", overflow, 0);
    frame(16'h0022, 8, rxd);
    check("bp_msg2", recv_msg, 8'h11);
    check("bp_ovf2", overflow, 1);
    recv_rdy = 1'b1;
    wait_clk(4);
    check("bp_drain_cnt", acc_cnt - a0, 1);
    check("bp_drain_data", last_acc, 8'h11);
    check("bp_val_after", recv_val, 0);
    check("ovf_sticky", overflow, 1);

    do_reset();
    check("ovf_cleared", overflow, 0);

    // bad lengths are dropped silently
    a0 = acc_cnt;
    frame(16'h007F, 7, rxd);
    frame(16'h01FF, 9, rxd);
    check("badlen_acc", acc_cnt - a0, 0);
    check("badlen_val", recv_val, 0);
    check("badlen_ovf", overflow, 0);
    frame(16'h005A, 8, rxd);
    check("after_bad_acc", acc_cnt - a0, 1);
    check("after_bad_data", last_acc, 8'h5A);

    // reset in the middle of a frame
    send_val = 1'b1;
    send_msg = 8'hFF;
    cs = 1'b0;
    wait_clk(10);
    send_val = 1'b0;
    for (int unsigned i = 0; i < 4; i++) sclk_bit(1'b1, m);
    wait_clk(2);
    check("mid_busy", busy, 1);
    check("mid_miso", miso, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_val", recv_val, 0);
    check("mid_rst_msg", recv_msg, 0);
    check("mid_rst_ovf", overflow, 0);
    cs = 1'b1;
    mosi = 1'b0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(4);
    a0 = acc_cnt;
    frame(16'h00C3, 8, rxd);
    check("post_rst_acc", acc_cnt - a0, 1);
    check("post_rst_data", last_acc, 8'hC3);
    check("post_rst_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
